// File: rtl/filtro_datapath_if.sv
// ----------------------------------------------------------------------------
// filtro_datapath_if
// Bundles the controller-to-datapath select bus and the sample in/out lines.
//   master : filter control FSM side (drives selects, receives y_out/y_valid)
//   slave  : filtro_datapath side
// Signals:
//   Bandera    new-sample strobe, x_in captured while high
//   x_in       signed input sample
//   sel_const  coefficient select (0..4 -> C0..C4, 5..7 -> 0)
//   sel_fun    operand select (00 x0, 01 x1, 10 y1, 11 y2)
//   sel_acum   accumulator op (00 hold, 01 load, 10 add, 11 clear)
//   SH_R       shift input delay line
//   Band_Listo end of sample period, commit output
//   y_out      registered filtered sample
//   y_valid    one-cycle strobe, y_out updated
// ----------------------------------------------------------------------------
interface filtro_datapath_if #(
   parameter int DATA_W = 16
);
   logic                     Bandera;
   logic signed [DATA_W-1:0] x_in;
   logic [2:0]               sel_const;
   logic [1:0]               sel_fun;
   logic [1:0]               sel_acum;
   logic                     SH_R;
   logic                     Band_Listo;
   logic signed [DATA_W-1:0] y_out;
   logic                     y_valid;

   modport master (
      output Bandera, x_in, sel_const, sel_fun, sel_acum, SH_R, Band_Listo,
      input  y_out, y_valid
   );

   modport slave (
      input  Bandera, x_in, sel_const, sel_fun, sel_acum, SH_R, Band_Listo,
      output y_out, y_valid
   );
endinterface

// File: rtl/filtro_datapath.sv
// ----------------------------------------------------------------------------
// filtro_datapath
// Arithmetic datapath of the fixed-point IIR filter. Holds the input taps
// (x0, x1), output taps (y1, y2) and the product accumulator. Each cycle the
// controller picks an operand and a coefficient; their product is loaded,
// added or ignored by sel_acum. On Band_Listo the next accumulator value is
// rounded half-up, saturated to DATA_W and committed to y_out / y1, with y2
// taking the old y1, and y_valid pulses on the following cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high, clears every register
//   bus    filtro_datapath_if.slave (selects, x_in, y_out, y_valid)
// ----------------------------------------------------------------------------
module filtro_datapath #(
   parameter int                       DATA_W = 16,
   parameter int                       FRAC   = 8,
   parameter int                       ACC_W  = 40,
   parameter logic signed [DATA_W-1:0] C0     = '0,
   parameter logic signed [DATA_W-1:0] C1     = '0,
   parameter logic signed [DATA_W-1:0] C2     = '0,
   parameter logic signed [DATA_W-1:0] C3     = '0,
   parameter logic signed [DATA_W-1:0] C4     = '0
) (
   input  logic               clk,
   input  logic               reset,
   filtro_datapath_if.slave   bus
);

   localparam int PROD_W = 2 * DATA_W;
   // One guard bit so the rounding bias can never wrap the accumulator value.
   localparam int RND_W  = ACC_W + 1;

   logic signed [DATA_W-1:0] x0, x1, y1, y2;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] y_out_r;
   logic                     y_valid_r;

   logic signed [DATA_W-1:0] coef_p0;
   logic signed [DATA_W-1:0] oper_p0;
   logic signed [PROD_W-1:0] prod_full_p0;
   logic signed [ACC_W-1:0]  prod_p0;
   logic signed [ACC_W-1:0]  acc_next_p0;
   logic signed [DATA_W-1:0] y_new_p0;

   // (v + 2^(FRAC-1)) >>> FRAC, computed one bit wider than the accumulator.
   function automatic logic signed [RND_W-1:0] round_half_up(
      input logic signed [ACC_W-1:0] v
   );
      logic signed [RND_W-1:0] ext;
      logic signed [RND_W-1:0] half;
      logic signed [RND_W-1:0] sum;
      ext           = {v[ACC_W-1], v};
      half          = '0;
      half[FRAC-1]  = 1'b1;
      sum           = ext + half;
      return sum >>> FRAC;
   endfunction

   // Clamp to the DATA_W signed range: in range iff all bits above the
   // result sign bit agree with it.
   function automatic logic signed [DATA_W-1:0] saturate(
      input logic signed [RND_W-1:0] v
   );
      if ((&v[RND_W-1:DATA_W-1]) || (~|v[RND_W-1:DATA_W-1]))
         return v[DATA_W-1:0];
      else if (v[RND_W-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // ---- stage p0: operand/coefficient select, multiply, accumulate, round
   always_comb begin
      coef_p0 = '0;
      case (bus.sel_const)
         3'd0:    coef_p0 = C0;
         3'd1:    coef_p0 = C1;
         3'd2:    coef_p0 = C2;
         3'd3:    coef_p0 = C3;
         3'd4:    coef_p0 = C4;
         default: coef_p0 = '0;
      endcase
   end

   always_comb begin
      oper_p0 = x0;
      case (bus.sel_fun)
         2'b00: oper_p0 = x0;
         2'b01: oper_p0 = x1;
         2'b10: oper_p0 = y1;
         2'b11: oper_p0 = y2;
         default: oper_p0 = x0;
      endcase
   end

   assign prod_full_p0 = PROD_W'(oper_p0) * PROD_W'(coef_p0);
   assign prod_p0      = {{(ACC_W-PROD_W){prod_full_p0[PROD_W-1]}}, prod_full_p0};

   always_comb begin
      acc_next_p0 = acc;
      case (bus.sel_acum)
         2'b00: acc_next_p0 = acc;
         2'b01: acc_next_p0 = prod_p0;
         2'b10: acc_next_p0 = acc + prod_p0;  // wraps at ACC_W by design
         2'b11: acc_next_p0 = '0;
         default: acc_next_p0 = acc;
      endcase
   end

   // The commit sees acc_next so the product of the Band_Listo cycle counts.
   assign y_new_p0 = saturate(round_half_up(acc_next_p0));

   // ---- stage p1: registered state and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0        <= '0;
         x1        <= '0;
         y1        <= '0;
         y2        <= '0;
         acc       <= '0;
         y_out_r   <= '0;
         y_valid_r <= 1'b0;
      end else begin
         acc <= acc_next_p0;
         if (bus.Bandera)
            x0 <= bus.x_in;
         if (bus.SH_R)
            x1 <= x0;
         if (bus.Band_Listo) begin
            y_out_r <= y_new_p0;
            y1      <= y_new_p0;
            y2      <= y1;
         end
         y_valid_r <= bus.Band_Listo;
      end
   end

   assign bus.y_out   = y_out_r;
   assign bus.y_valid = y_valid_r;

endmodule

// File: tb/tb_filtro_datapath.sv
module tb_filtro_datapath;

   localparam int DATA_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset;
   logic                     bandera;
   logic signed [DATA_W-1:0] x_in;
   logic [2:0]               sel_const;
   logic [1:0]               sel_fun;
   logic [1:0]               sel_acum;
   logic                     sh_r;
   logic                     listo;

   int checks   = 0;
   int failures = 0;

   filtro_datapath_if #(.DATA_W(DATA_W)) if_a ();
   filtro_datapath_if #(.DATA_W(DATA_W)) if_s ();
   filtro_datapath_if #(.DATA_W(DATA_W)) if_n ();
   filtro_datapath_if #(.DATA_W(DATA_W)) if_i ();

   assign if_a.Bandera = bandera;  assign if_a.x_in = x_in;  assign if_a.sel_const = sel_const;
   assign if_a.sel_fun = sel_fun;  assign if_a.sel_acum = sel_acum;
   assign if_a.SH_R = sh_r;        assign if_a.Band_Listo = listo;
   assign if_s.Bandera = bandera;  assign if_s.x_in = x_in;  assign if_s.sel_const = sel_const;
   assign if_s.sel_fun = sel_fun;  assign if_s.sel_acum = sel_acum;
   assign if_s.SH_R = sh_r;        assign if_s.Band_Listo = listo;
   assign if_n.Bandera = bandera;  assign if_n.x_in = x_in;  assign if_n.sel_const = sel_const;
   assign if_n.sel_fun = sel_fun;  assign if_n.sel_acum = sel_acum;
   assign if_n.SH_R = sh_r;        assign if_n.Band_Listo = listo;
   assign if_i.Bandera = bandera;  assign if_i.x_in = x_in;  assign if_i.sel_const = sel_const;
   assign if_i.sel_fun = sel_fun;  assign if_i.sel_acum = sel_acum;
   assign if_i.SH_R = sh_r;        assign if_i.Band_Listo = listo;

   // Impulse / rounding / delay-line instance
   filtro_datapath #(.C0(16'sh0080)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
   // Positive and negative saturation instances
   filtro_datapath #(.C0(16'sh7FFF)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
   filtro_datapath #(.C0(16'sh8000)) dut_n (.clk(clk), .reset(reset), .bus(if_n));
   // Integrated IIR instance, all coefficients 1.0
   filtro_datapath #(.C0(16'sh0100), .C1(16'sh0100), .C2(16'sh0100),
                     .C3(16'sh0100), .C4(16'sh0100)) dut_i (.clk(clk), .reset(reset), .bus(if_i));

   typedef struct {
      logic                     b;
      logic signed [DATA_W-1:0] x;
      logic [2:0]               c;
      logic [1:0]               f;
      logic [1:0]               a;
      logic                     s;
      logic                     l;
      logic signed [DATA_W-1:0] ey;
      logic                     ev;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic b, input logic signed [DATA_W-1:0] x,
                               input logic [2:0] c, input logic [1:0] f, input logic [1:0] a,
                               input logic s, input logic l,
                               input logic signed [DATA_W-1:0] ey, input logic ev);
      vec_t v;
      v.b = b; v.x = x; v.c = c; v.f = f; v.a = a; v.s = s; v.l = l; v.ey = ey; v.ev = ev;
      return v;
   endfunction

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of selects, clock it, sample 1 time unit after the edge.
   task automatic drive(input logic b, input logic signed [DATA_W-1:0] x,
                        input logic [2:0] c, input logic [1:0] f, input logic [1:0] a,
                        input logic s, input logic l);
      bandera = b; x_in = x; sel_const = c; sel_fun = f; sel_acum = a; sh_r = s; listo = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
   endtask

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   longint mx0, mx1, my1, my2, macc, mr;

   initial begin
      reset = 1'b1;
      bandera = 1'b0; x_in = '0; sel_const = '0; sel_fun = '0; sel_acum = '0; sh_r = 1'b0; listo = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset_y_out", if_a.y_out, 0);
      check("reset_y_valid", if_a.y_valid, 0);
      reset = 1'b0;

      // ---------------- table-driven vectors on dut_a (C0 = 0.5) ----------
      //                 b     x            c     f      a      s     l     ey           ev
      tbl.push_back(mk(1'b1, 16'sh0100, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0000, 1'b0));
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0080, 1'b1)); // impulse
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0080, 1'b0));
      tbl.push_back(mk(1'b1, 16'sh0001, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0080, 1'b0));
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 16'sh0080, 1'b0)); // load 0x80
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b10, 1'b0, 1'b1, 16'sh0001, 1'b1)); // acc 0x100
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0001, 1'b1)); // 0x80 rounds up
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b11, 1'b0, 1'b1, 16'sh0000, 1'b1)); // clear
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0000, 1'b0));
      tbl.push_back(mk(1'b1, -16'sd1,   3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0000, 1'b0));
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0000, 1'b1)); // -0.5 -> 0
      tbl.push_back(mk(1'b1, -16'sd3,   3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0000, 1'b0));
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, -16'sd1,   1'b1)); // -1.5 -> -1
      tbl.push_back(mk(1'b1, 16'sh0005, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, -16'sd1,   1'b0)); // x1=-3,x0=5
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b01, 2'b01, 1'b0, 1'b1, -16'sd1,   1'b1)); // x1 operand
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0003, 1'b1)); // x0 operand
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b10, 2'b01, 1'b0, 1'b1, 16'sh0002, 1'b1)); // y1=3
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b11, 2'b01, 1'b0, 1'b1, 16'sh0002, 1'b1)); // y2=3
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd5, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0000, 1'b1)); // sel 5 -> 0
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd1, 2'b00, 2'b01, 1'b0, 1'b1, 16'sh0000, 1'b1)); // C1 = 0
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 16'sh0000, 1'b0)); // acc=640
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 16'sh0003, 1'b1)); // hold
      tbl.push_back(mk(1'b0, 16'sh0000, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'sh0003, 1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].b, tbl[i].x, tbl[i].c, tbl[i].f, tbl[i].a, tbl[i].s, tbl[i].l);
         check($sformatf("vec%0d_y_out", i), if_a.y_out, tbl[i].ey);
         check($sformatf("vec%0d_y_valid", i), if_a.y_valid, tbl[i].ev);
         if (i == 1) check("impulse_y1", dut_a.y1, 16'sh0080);
      end

      // ---------------- delay line ----------------
      drive(1'b1, 16'sd5, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 16'sd7, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0);
      check("dl_x0", dut_a.x0, 7);
      check("dl_x1", dut_a.x1, 5);
      drive(1'b0, '0, 3'd0, 2'b01, 2'b01, 1'b0, 1'b1);   // 5*0.5 -> 3
      check("dl_commit3", if_a.y_out, 3);
      drive(1'b0, '0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1);   // 7*0.5 -> 4
      check("dl_commit4", if_a.y_out, 4);
      check("dl_y1", dut_a.y1, 4);
      check("dl_y2", dut_a.y2, 3);

      // ---------------- Bandera held high ----------------
      drive(1'b1, 16'sd11, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      check("held_x0_a", dut_a.x0, 11);
      drive(1'b1, 16'sd12, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      check("held_x0_b", dut_a.x0, 12);
      drive(1'b1, 16'sd13, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      idle();
      check("held_x0_last", dut_a.x0, 13);

      // ---------------- saturation ----------------
      drive(1'b1, 16'sh7FFF, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      drive(1'b0, '0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0);
      drive(1'b0, '0, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0);
      drive(1'b0, '0, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0);
      drive(1'b0, '0, 3'd0, 2'b00, 2'b10, 1'b0, 1'b1);
      check("sat_pos", if_s.y_out, 32767);
      check("sat_neg", if_n.y_out, -32768);
      check("sat_valid", if_s.y_valid, 1);

      // ---------------- reset between edges ----------------
      #2 reset = 1'b1;
      #1;
      check("midrst_y_out", if_s.y_out, 0);
      check("midrst_y_valid", if_s.y_valid, 0);
      check("midrst_acc", dut_s.acc, 0);
      check("midrst_x0", dut_s.x0, 0);
      check("midrst_y1", dut_s.y1, 0);
      #1 reset = 1'b0;
      drive(1'b0, '0, 3'd0, 2'b10, 2'b01, 1'b0, 1'b1);   // y1 after reset is 0
      check("postrst_commit", if_s.y_out, 0);
      check("postrst_valid", if_s.y_valid, 1);

      // ---------------- integrated IIR, 20 samples ----------------
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      mx0 = 0; mx1 = 0; my1 = 0; my2 = 0;
      for (int s = 0; s < 20; s++) begin
         mx0  = 256;
         macc = 256 * mx1;
         macc = macc + 256 * my1;
         mx1  = mx0;
         macc = macc + 256 * mx1;
         macc = macc + 256 * my1;
         mr   = sat16((macc + 128) >>> 8);
         my2  = my1;
         my1  = mr;

         drive(1'b1, 16'sh0100, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
         check($sformatf("iir%0d_idle_valid", s), if_i.y_valid, 0);
         drive(1'b0, '0, 3'd0, 2'b01, 2'b01, 1'b0, 1'b0);
         drive(1'b0, '0, 3'd1, 2'b10, 2'b10, 1'b1, 1'b0);
         drive(1'b0, '0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0);
         drive(1'b0, '0, 3'd3, 2'b01, 2'b10, 1'b0, 1'b0);
         drive(1'b0, '0, 3'd4, 2'b10, 2'b10, 1'b0, 1'b1);
         check($sformatf("iir%0d_y_out", s), if_i.y_out, mr);
         check($sformatf("iir%0d_valid", s), if_i.y_valid, 1);
         check($sformatf("iir%0d_y2", s), dut_i.y2, my2);
      end
      idle();
      check("iir_valid_drop", if_i.y_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/filtro_datapath.md
# filtro_datapath

Arithmetic datapath of the fixed-point digital filter, directly downstream of the filter control FSM. It captures a new input sample, keeps the input/output delay line, multiplies the selected operand by the selected coefficient, and accumulates the products over one sample period, all under cycle-by-cycle selects from the controller. At the controller's done flag it rounds and saturates the accumulator into the output sample, updates the feedback taps and pulses a valid strobe.

## Interface
- DATA_W, 16, signed sample and coefficient width
- FRAC, 8, fractional bits of samples and coefficients (Q(DATA_W-FRAC).FRAC)
- ACC_W, 40, accumulator width (≥ 2*DATA_W + 3)
- C0..C4, 16'sh0000, signed coefficients selected by sel_const 0..4
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers
- Bandera  in  1  new-sample strobe (same signal that restarts the controller)
- x_in  in  DATA_W  signed input sample, sampled while Bandera=1
- sel_const  in  3  coefficient select; 0..4 → C0..C4, 5..7 → 0
- sel_fun  in  2  operand select: 00 x0, 01 x1, 10 y1, 11 y2
- sel_acum  in  2  00 hold, 01 load product, 10 acc+product, 11 clear
- SH_R  in  1  shift input delay line
- Band_Listo  in  1  end of sample period: commit output
- y_out  out  DATA_W  signed filtered sample (registered)
- y_valid  out  1  one-cycle pulse, y_out updated

## Operation
- Registers: x0, x1 (input taps), y1, y2 (output taps), acc (ACC_W), y_out, y_valid.
- Reset: all of the above = 0 immediately on reset high, held while high.
- Bandera=1: x0 <= x_in. Datapath is otherwise unaffected (acc governed only by sel_acum).
- SH_R=1: x1 <= x0 (value before this edge). Bandera and SH_R in same cycle: x1 gets old x0, x0 gets x_in.
- prod = operand * coef, full 2*DATA_W signed, sign-extended to ACC_W; format Q.(2*FRAC).
- acc_next: 00 acc; 01 prod; 10 acc+prod (wraps at ACC_W, no saturation in acc); 11 0. acc <= acc_next every cycle.
- Band_Listo=1: r = (acc_next + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift); y_new = saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; y_out <= y_new; y2 <= y1; y1 <= y_new. Commit includes the product of the Band_Listo cycle.
- y_valid <= Band_Listo (registered; high exactly one cycle per commit unless Band_Listo held).
- No internal FSM beyond these registers; sequencing belongs to the controller. Nominal per-sample sequence from the controller: (c0,x1,load) (c1,y1,acc,SH_R) (c2,x0,hold) (c3,x1,acc) (c4,y1,acc,Listo).

## Timing
- Selects are combinational from the controller's registered state and consumed in the same cycle; no input registering.
- Product-to-acc latency 1 cycle; Band_Listo edge to y_out/y_valid: both visible after the same rising edge (y_valid high the cycle after Band_Listo was high).
- Back-to-back Band_Listo cycles: each commits; y1/y2 shift each time.
- Reset mid-period: acc, taps, y_out cleared at once; y_valid drops asynchronously; first post-reset commit uses zeroed taps.
- Bandera held high several cycles: x0 follows x_in each cycle; last value retained.

## Test plan
- Reset: drive taps/acc nonzero, assert reset between edges → all outputs 0 before next edge, y_valid=0.
- Impulse (C0=16'sh0080, others 0): Bandera with x_in=16'sh0100, then sel_fun=00, sel_const=0, sel_acum=01 with Band_Listo → y_out=16'sh0080, y_valid one cycle, y1=16'sh0080.
- Accumulate/rounding: x0=16'sh0001, C0=16'sh0080, load then acc same product with Listo → acc=0x100 → y_out=16'sh0001; single product (0x80) → rounds to 16'sh0001.
- Saturation: x0=16'sh7FFF, C0=16'sh7FFF, three acc cycles then Listo → y_out=16'sh7FFF; with C0=16'sh8000 → y_out=16'sh8000.
- Delay line: Bandera x_in=5 then 7 with SH_R on second Bandera cycle → x0=7, x1=5; two commits of 3 then 4 → y1=4, y2=3.
- Integrated with controller, C0..C4=16'sh0100, constant x_in=16'sh0100: y_out sequence after each Band_Listo matches golden IIR model bit-exactly for 20 samples.
